// File: rtl/minmax_pkg.sv
// Shared types and constants for the block min/max/threshold tracker.
package minmax_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_BLOCK_LEN = 8;

  // Counter width able to hold the value n itself.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mag_cmp.sv
// Unsigned WIDTH-bit magnitude comparator: one-hot gt / eq / lt of a against b.
module mag_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  assign gt = (a > b);
  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/minmax_tracker.sv
// Block tracker: running max/min and eq/gt-threshold counts over BLOCK_LEN samples.
// Define MINMAX_INDEX_EN to add first-occurrence positions of max and min.
module minmax_tracker
  import minmax_pkg::*;
#(
  parameter  int WIDTH     = DEF_WIDTH,
  parameter  int BLOCK_LEN = DEF_BLOCK_LEN,
  localparam int CNT_W     = cnt_w(BLOCK_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] threshold,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic [CNT_W-1:0] out_eq_cnt,
  output logic [CNT_W-1:0] out_gt_cnt
`ifdef MINMAX_INDEX_EN
  ,
  output logic [CNT_W-1:0] out_max_idx,
  output logic [CNT_W-1:0] out_min_idx
`endif
);

  localparam int NCMP = 3;
  localparam int C_MAX = 0;
  localparam int C_MIN = 1;
  localparam int C_THR = 2;

  state_t state_q, state_d;

  logic [WIDTH-1:0] max_q, min_q, thr_q;
  logic [CNT_W-1:0] eq_q, gt_q, cnt_q;

  logic accept, last_smp;

  logic [NCMP-1:0][WIDTH-1:0] cmp_b;
  logic [NCMP-1:0]            cmp_gt, cmp_eq, cmp_lt;
  logic                       cmp_unused;

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;
  assign last_smp  = (state_q == ACCUM) && (cnt_q == CNT_W'(BLOCK_LEN - 1));

  // The first sample of a block compares against the live port; later ones use the latched copy.
  assign cmp_b[C_MAX] = max_q;
  assign cmp_b[C_MIN] = min_q;
  assign cmp_b[C_THR] = (state_q == IDLE) ? threshold : thr_q;

  for (genvar g = 0; g < NCMP; g++) begin : g_cmp
    mag_cmp #(.WIDTH(WIDTH)) u_cmp (
      .a  (in_data),
      .b  (cmp_b[g]),
      .gt (cmp_gt[g]),
      .eq (cmp_eq[g]),
      .lt (cmp_lt[g])
    );
  end

  assign cmp_unused = &{1'b0, cmp_eq[C_MIN:C_MAX], cmp_gt[C_MIN], cmp_lt[C_THR], cmp_lt[C_MAX]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACCUM;
      ACCUM:   if (accept && last_smp) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      max_q   <= '0;
      min_q   <= '0;
      thr_q   <= '0;
      eq_q    <= '0;
      gt_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (state_q == IDLE) begin
          max_q <= in_data;
          min_q <= in_data;
          thr_q <= threshold;
          eq_q  <= CNT_W'(cmp_eq[C_THR]);
          gt_q  <= CNT_W'(cmp_gt[C_THR]);
          cnt_q <= CNT_W'(1);
        end else begin
          if (cmp_gt[C_MAX]) max_q <= in_data;
          if (cmp_lt[C_MIN]) min_q <= in_data;
          eq_q  <= eq_q + CNT_W'(cmp_eq[C_THR]);
          gt_q  <= gt_q + CNT_W'(cmp_gt[C_THR]);
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign out_max    = max_q;
  assign out_min    = min_q;
  assign out_eq_cnt = eq_q;
  assign out_gt_cnt = gt_q;

`ifdef MINMAX_INDEX_EN
  logic [CNT_W-1:0] max_idx_q, min_idx_q;

  // cnt_q equals the 0-based position of the sample being accepted in ACCUM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_idx_q <= '0;
      min_idx_q <= '0;
    end else if (accept) begin
      if (state_q == IDLE) begin
        max_idx_q <= '0;
        min_idx_q <= '0;
      end else begin
        if (cmp_gt[C_MAX]) max_idx_q <= cnt_q;
        if (cmp_lt[C_MIN]) min_idx_q <= cnt_q;
      end
    end
  end

  assign out_max_idx = max_idx_q;
  assign out_min_idx = min_idx_q;
`else
  // Position tracking not built.
`endif

endmodule

// File: tb/tb_minmax_tracker.sv
// Directed + random bench for minmax_tracker with a record scoreboard.
module tb_minmax_tracker;
  import minmax_pkg::*;

  localparam int W  = 4;
  localparam int BL = 8;
  localparam int CW = 4;

  typedef struct {
    logic [W-1:0]  mx, mn;
    logic [CW-1:0] eq, gt, mxi, mni;
  } rec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [W-1:0] in_data = '0, threshold = '0, out_max, out_min;
  logic [CW-1:0] out_eq_cnt, out_gt_cnt;
`ifdef MINMAX_INDEX_EN
  logic [CW-1:0] out_max_idx, out_min_idx;
`endif

  int n_cmp = 0, n_fail = 0;
  rec_t sb[$];

  always #5 clk = ~clk;

  minmax_tracker #(.WIDTH(W), .BLOCK_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .threshold(threshold),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_max(out_max), .out_min(out_min), .out_eq_cnt(out_eq_cnt), .out_gt_cnt(out_gt_cnt)
`ifdef MINMAX_INDEX_EN
    , .out_max_idx(out_max_idx), .out_min_idx(out_min_idx)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: a record seen here transfers on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) chk("spurious_record", 32'd1, 32'd0);
      else begin
        rec_t r;
        r = sb.pop_front();
        chk("rec_max", out_max, r.mx);
        chk("rec_min", out_min, r.mn);
        chk("rec_eq",  out_eq_cnt, r.eq);
        chk("rec_gt",  out_gt_cnt, r.gt);
`ifdef MINMAX_INDEX_EN
        chk("rec_max_idx", out_max_idx, r.mxi);
        chk("rec_min_idx", out_min_idx, r.mni);
`endif
      end
    end
  end

  function automatic rec_t model(input logic [W-1:0] s [BL], input logic [W-1:0] thr);
    rec_t r;
    r.mx = s[0]; r.mn = s[0]; r.mxi = '0; r.mni = '0; r.eq = '0; r.gt = '0;
    for (int i = 0; i < BL; i++) begin
      if (s[i] > r.mx) begin r.mx = s[i]; r.mxi = CW'(i); end
      if (s[i] < r.mn) begin r.mn = s[i]; r.mni = CW'(i); end
      if (s[i] == thr) r.eq++;
      if (s[i] > thr)  r.gt++;
    end
    return r;
  endfunction

  // Present one sample from a falling edge; returns #1 after the accepting edge.
  task automatic drive(input logic [W-1:0] v, input logic [W-1:0] thr);
    int b = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = v; threshold = thr;
    while (!in_ready && b < 50) begin @(negedge clk); b++; end
    if (b >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_block(input logic [W-1:0] s [BL], input logic [W-1:0] thr0,
                            input logic [W-1:0] thr1, input int gmax, input bit push);
    if (push) sb.push_back(model(s, thr0));
    for (int i = 0; i < BL; i++) begin
      drive(s[i], (i == 0) ? thr0 : thr1);
      if (i == BL - 2) chk("out_valid_before_last", out_valid, 1'b0);
      if (i == BL - 1) begin
        chk("out_valid_after_last", out_valid, 1'b1);
        chk("in_ready_in_hold", in_ready, 1'b0);
      end
      if (i < BL - 1 && gmax > 0) begin
        int g = $urandom_range(0, gmax);
        if (g > 0) begin
          @(negedge clk); in_valid = 1'b0;
          repeat (g - 1) @(negedge clk);
        end
      end
    end
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int b = 0;
    while (out_valid && b < 100) begin @(posedge clk); #1; b++; end
    if (b >= 100) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [W-1:0] blk [BL];
    logic [W-1:0] hold_max;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_max", out_max, 4'd0);
    chk("rst_min", out_min, 4'd0);
    chk("rst_eq", out_eq_cnt, 4'd0);
    chk("rst_gt", out_gt_cnt, 4'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", in_ready, 1'b1);

    // Mixed block with extreme values
    blk = '{4'd3, 4'd9, 4'd1, 4'd9, 4'd0, 4'd15, 4'd7, 4'd1};
    send_block(blk, 4'd7, 4'd7, 0, 1'b1);
    wait_idle();

    // All samples equal to threshold
    blk = '{default: 4'd5};
    send_block(blk, 4'd5, 4'd5, 0, 1'b1);
    wait_idle();

    // Back-pressure in HOLD with junk in_valid
    out_ready = 1'b0;
    blk = '{4'd2, 4'd14, 4'd6, 4'd6, 4'd1, 4'd3, 4'd14, 4'd8};
    send_block(blk, 4'd6, 4'd6, 0, 1'b1);
    hold_max = 4'd14;
    repeat (10) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 4'd15;
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_out_valid", out_valid, 1'b1);
      chk("stall_max", out_max, hold_max);
      chk("stall_min", out_min, 4'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_idle();
    @(posedge clk); #1;
    chk("in_ready_after_xfer", in_ready, 1'b1);

    // Independent next block
    blk = '{4'd4, 4'd4, 4'd5, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4};
    send_block(blk, 4'd0, 4'd0, 0, 1'b1);
    wait_idle();

    // Threshold changes after the first sample
    blk = '{4'd7, 4'd0, 4'd8, 4'd7, 4'd2, 4'd9, 4'd7, 4'd1};
    send_block(blk, 4'd7, 4'd0, 0, 1'b1);
    wait_idle();

    // Reset after sample 4
    for (int i = 0; i < 4; i++) drive(4'(i + 10), 4'd3);
    in_valid = 1'b0; rst_n = 1'b0; #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_gt", out_gt_cnt, 4'd0);
    @(negedge clk); rst_n = 1'b1;

    // Reset while holding a record
    out_ready = 1'b0;
    blk = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    send_block(blk, 4'd4, 4'd4, 0, 1'b0);
    @(posedge clk); #1;
    chk("hold_before_rst", out_valid, 1'b1);
    rst_n = 1'b0; #1;
    chk("holdrst_out_valid", out_valid, 1'b0);
    chk("holdrst_max", out_max, 4'd0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;

    blk = '{4'd12, 4'd3, 4'd12, 4'd0, 4'd3, 4'd11, 4'd2, 4'd3};
    send_block(blk, 4'd3, 4'd3, 0, 1'b1);
    wait_idle();

    // Random blocks with idle gaps
    for (int b = 0; b < 100; b++) begin
      for (int i = 0; i < BL; i++) blk[i] = 4'($urandom_range(0, 15));
      send_block(blk, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 5, 1'b1);
      if (b % 7 == 3) begin
        out_ready = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1; out_ready = 1'b1;
      end
    end
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
